// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end: issues fetches at pc_out,
// delivers instructions over a valid/ready handshake backed by a one-entry skid buffer.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] pc_out,
    input  logic [63:0] pc_plus4_in,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    typedef enum logic {S_REQ, S_HOLD} state_t;

    state_t      state;
    logic        skid_valid;
    logic [63:0] skid_pc;
    logic [31:0] skid_instr;
    logic        kill;
    logic [63:0] redirect_pc;

    logic        slot_free;
    logic        ack_taken;
    logic [63:0] target_aligned;

    assign slot_free      = !if_valid || id_ready;
    assign ack_taken      = imem_req && imem_ack;
    assign target_aligned = {branch_target[63:2], 2'b00};

    // imem_req is registered so it is low during reset and rises one cycle after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc_out      <= RESET_PC;
            imem_req    <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= 64'h0;
            if_instr    <= 32'h0;
            skid_valid  <= 1'b0;
            skid_pc     <= 64'h0;
            skid_instr  <= 32'h0;
            kill        <= 1'b0;
            redirect_pc <= 64'h0;
        end else if (branch_taken) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
                // Pending fetch must still complete; its data is dropped when the ack arrives.
                redirect_pc <= target_aligned;
                kill        <= 1'b1;
            end else begin
                pc_out   <= target_aligned;
                kill     <= 1'b0;
                state    <= S_REQ;
                imem_req <= 1'b1;
            end
        end else begin
            case (state)
                S_REQ: begin
                    imem_req <= 1'b1;
                    if (ack_taken) begin
                        if (kill) begin
                            pc_out <= redirect_pc;
                            kill   <= 1'b0;
                            if (slot_free) begin
                                if_valid <= 1'b0;
                            end
                        end else if (slot_free) begin
                            if_pc    <= pc_out;
                            if_instr <= imem_rdata;
                            if_valid <= 1'b1;
                            pc_out   <= pc_plus4_in;
                        end else begin
                            skid_pc    <= pc_out;
                            skid_instr <= imem_rdata;
                            skid_valid <= 1'b1;
                            pc_out     <= pc_plus4_in;
                            state      <= S_HOLD;
                            imem_req   <= 1'b0;
                        end
                    end else if (slot_free) begin
                        if_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    imem_req <= 1'b0;
                    if (id_ready) begin
                        if_pc      <= skid_pc;
                        if_instr   <= skid_instr;
                        if_valid   <= 1'b1;
                        skid_valid <= 1'b0;
                        state      <= S_REQ;
                        imem_req   <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch/ack/ready/redirect vectors,
// expected deliveries queued by the stimulus and checked by an independent monitor.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_out;
    logic [63:0] pc_plus4_in;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready = 1'b1;

    int total = 0;
    int bad = 0;
    logic [95:0] expq[$];

    pc_fetch_unit #(.RESET_PC(64'h400)) dut (
        .clk(clk),
        .reset(reset),
        .pc_out(pc_out),
        .pc_plus4_in(pc_plus4_in),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    // External adder and memory model: word content is a fixed function of the address.
    assign pc_plus4_in = pc_out + 64'd4;
    assign imem_rdata  = instr_of(pc_out);

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expect_delivery(input logic [63:0] pc);
        expq.push_back({pc, instr_of(pc)});
    endtask

    task automatic apply_stimulus(input logic ack, input logic ready, input logic br, input logic [63:0] tgt);
        imem_ack      = ack;
        id_ready      = ready;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    // Decode squashes whatever it sees in a redirect cycle, so those handshakes are ignored.
    always @(negedge clk) begin
        if (!reset && !branch_taken && if_valid && id_ready) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_delivery: got pc %h instr %h expected none", if_pc, if_instr);
            end else begin
                logic [95:0] e;
                e = expq.pop_front();
                check_output("if_pc", if_pc, e[95:32]);
                check_output("if_instr", {32'h0, if_instr}, {32'h0, e[31:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and zero-wait stream
        reset = 1'b1;
        apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        check_output("rst_pc", pc_out, 64'h400);
        check_output("rst_req", {63'h0, imem_req}, 64'h0);
        check_output("rst_valid", {63'h0, if_valid}, 64'h0);
        check_output("rst_if_pc", if_pc, 64'h0);
        check_output("rst_if_instr", {32'h0, if_instr}, 64'h0);
        reset = 1'b0;
        apply_stimulus(0, 1, 0, 0);
        check_output("req_rise", {63'h0, imem_req}, 64'h1);
        check_output("no_valid_yet", {63'h0, if_valid}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            expect_delivery(64'h400 + 64'(4 * i));
            apply_stimulus(1, 1, 0, 0);
            if (i == 0) check_output("first_valid", {63'h0, if_valid}, 64'h1);
        end
        apply_stimulus(0, 1, 0, 0);

        // Backpressure into the skid buffer
        reset = 1'b1;
        expq.delete();
        apply_stimulus(0, 1, 0, 0);
        reset = 1'b0;
        apply_stimulus(0, 1, 0, 0);
        expect_delivery(64'h400);
        apply_stimulus(1, 0, 0, 0);
        expect_delivery(64'h404);
        apply_stimulus(1, 0, 0, 0);
        check_output("hold_req", {63'h0, imem_req}, 64'h0);
        check_output("hold_if_pc", if_pc, 64'h400);
        check_output("hold_pc", pc_out, 64'h408);
        apply_stimulus(0, 0, 0, 0);
        check_output("stall_if_pc", if_pc, 64'h400);
        check_output("stall_valid", {63'h0, if_valid}, 64'h1);
        apply_stimulus(0, 1, 0, 0);
        check_output("skid_out", if_pc, 64'h404);
        expect_delivery(64'h408);
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0);

        // Killed fetch
        reset = 1'b1;
        expq.delete();
        apply_stimulus(0, 1, 0, 0);
        reset = 1'b0;
        apply_stimulus(0, 1, 0, 0);
        expect_delivery(64'h400);
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 64'h800);
        check_output("kill_pc_held", pc_out, 64'h404);
        check_output("kill_valid", {63'h0, if_valid}, 64'h0);
        apply_stimulus(0, 1, 0, 0);
        check_output("kill_req", {63'h0, imem_req}, 64'h1);
        apply_stimulus(1, 1, 0, 0);
        check_output("kill_redirect_pc", pc_out, 64'h800);
        check_output("kill_dropped", {63'h0, if_valid}, 64'h0);
        expect_delivery(64'h800);
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0);

        // Flush while holding a full skid
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        check_output("flush_hold_req", {63'h0, imem_req}, 64'h0);
        apply_stimulus(0, 1, 1, 64'h803);
        check_output("flush_pc", pc_out, 64'h800);
        check_output("flush_valid", {63'h0, if_valid}, 64'h0);
        check_output("flush_req", {63'h0, imem_req}, 64'h1);
        expect_delivery(64'h800);
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0);

        // Wrap at the top of the address space
        apply_stimulus(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        check_output("wrap_target", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_delivery(64'hFFFF_FFFF_FFFF_FFFC);
        apply_stimulus(1, 1, 0, 0);
        check_output("wrap_pc", pc_out, 64'h0);
        expect_delivery(64'h0);
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        check_output("post_wrap_pc", pc_out, 64'h4);

        // Reset during S_HOLD
        expect_delivery(64'h4);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        check_output("mid_hold_req", {63'h0, imem_req}, 64'h0);
        reset = 1'b1;
        expq.delete();
        apply_stimulus(0, 0, 0, 0);
        check_output("mid_rst_valid", {63'h0, if_valid}, 64'h0);
        check_output("mid_rst_req", {63'h0, imem_req}, 64'h0);
        check_output("mid_rst_pc", pc_out, 64'h400);
        reset = 1'b0;
        apply_stimulus(0, 1, 0, 0);
        expect_delivery(64'h400);
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        check_output("after_rst_pc", pc_out, 64'h404);

        check_output("drain", 64'(expq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
